// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_pkg
// Description : Shared pipeline types and constants for the five-stage core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

    function automatic logic reg_match(
        input logic             used,
        input logic [REG_W-1:0] a,
        input logic [REG_W-1:0] b
    );
        return used && (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_busy_counter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_busy_counter
// Description : Down-counter tracking how long a mul/div occupies EX.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_busy_counter #(
    parameter int MD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic busy,
    output logic done
);

    localparam logic [7:0] c_md_load = 8'(MD_CYCLES);

    logic [7:0] r_md_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= 8'd0;
        end else if (load) begin
            r_md_cnt <= c_md_load;
        end else if (count && (r_md_cnt != 8'd0)) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    assign busy = (r_md_cnt != 8'd0);
    assign done = count && (r_md_cnt == 8'd1);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Load-use / branch / mul-div hold and flush control for the
//               five-stage pipeline. HAZARD_STALL_CNT_EN adds stall_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int MD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_muldiv,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    hz_state_t r_state;
    hz_state_t w_state_nxt;
    logic      w_lu_haz;
    logic      w_md_load;
    logic      w_md_count;
    logic      w_cnt_busy;
    logic      w_cnt_done;

    assign w_lu_haz = ex_mem_read && (ex_rt != REG_ZERO) &&
                      (reg_match(id_uses_rs, id_rs, ex_rt) ||
                       reg_match(id_uses_rt, id_rt, ex_rt));

    muldiv_busy_counter #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (w_md_load),
        .count (w_md_count),
        .busy  (w_cnt_busy),
        .done  (w_cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_md_load   = 1'b0;
        w_md_count  = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        if (!reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_lu_haz) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                    end else if (id_muldiv) begin
                        w_md_load   = 1'b1;
                        w_state_nxt = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    // EX is occupied by the mul/div; branch and load info there is stale.
                    w_md_count  = 1'b1;
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_flush = 1'b1;
                    md_busy     = w_cnt_busy;
                    md_done     = w_cnt_done;
                    if (w_cnt_done) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'd0;
        end else if (pc_hold && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire
